// File: rtl/mem_stage_pkg.sv
// Shared MEM-stage definitions: datapath widths, FSM encoding and the
// bubble values loaded into MEM/WB while the stage is stalled.
package mem_stage_pkg;

  localparam int REG_W = 16;
  localparam int RD_W  = 3;
  localparam int CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_t;

  localparam logic [REG_W-1:0] BUBBLE_REG = '0;
  localparam logic [RD_W-1:0]  BUBBLE_RD  = '0;
  localparam logic             BUBBLE_RW  = 1'b0;
  localparam logic             BUBBLE_M2R = 1'b0;

endpackage

// File: rtl/mem_stage_if.sv
// EX/MEM inputs, MEM/WB outputs and forwarding taps of the MEM stage.
// master = upstream pipeline / write-back side, slave = mem_stage.
interface mem_stage_if;
  import mem_stage_pkg::*;

  logic [REG_W-1:0] ALU_result_mem;
  logic [REG_W-1:0] Rs_data_mem;
  logic [RD_W-1:0]  Rd_mem;
  logic             memRead_mem;
  logic             memWrite_mem;
  logic             regWrite_mem;

  logic             stall_o;
  logic [REG_W-1:0] ALU_result_wb;
  logic [REG_W-1:0] mem_data_wb;
  logic [RD_W-1:0]  Rd_wb;
  logic             regWrite_wb;
  logic             memToReg_wb;

  logic [REG_W-1:0] fwd_data_o;
  logic [RD_W-1:0]  fwd_Rd_o;
  logic             fwd_regWrite_o;

  modport master (
    output ALU_result_mem, Rs_data_mem, Rd_mem, memRead_mem, memWrite_mem, regWrite_mem,
    input  stall_o, ALU_result_wb, mem_data_wb, Rd_wb, regWrite_wb, memToReg_wb,
    input  fwd_data_o, fwd_Rd_o, fwd_regWrite_o
  );

  modport slave (
    input  ALU_result_mem, Rs_data_mem, Rd_mem, memRead_mem, memWrite_mem, regWrite_mem,
    output stall_o, ALU_result_wb, mem_data_wb, Rd_wb, regWrite_wb, memToReg_wb,
    output fwd_data_o, fwd_Rd_o, fwd_regWrite_o
  );

endinterface

// File: rtl/mem_stage_data_mem.sv
// Single-port 16-bit data memory. Synchronous write, registered read that
// returns the word as it was before the same-edge write (read-before-write).
// rdata holds its value when no read is enabled.
module mem_stage_data_mem
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] addr,
  input  logic [REG_W-1:0]  wdata,
  output logic [REG_W-1:0]  rdata
);

  logic [REG_W-1:0] mem [0:(1<<ADDR_W)-1];

  // array write; contents survive reset, but a write coinciding with reset is dropped
  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[addr] <= wdata;
  end

  // registered read of the pre-edge word
  always_ff @(posedge clk) begin
    if (rst)        rdata <= '0;
    else if (rd_en) rdata <= mem[addr];
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: data memory access with a fixed number of wait
// states, MEM/WB pipeline register, and forwarding taps.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int ADDR_W      = 12,
  parameter int WAIT_STATES = 0
) (
  input  logic    clk,
  input  logic    rst,
  mem_stage_if.slave bus
);

  localparam logic [CNT_W-1:0] CNT_LOAD =
    (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : '0;
  localparam bit HAS_WAIT = (WAIT_STATES > 0);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             access;
  logic             complete;
  logic             stall;
  logic [ADDR_W-1:0] addr;

  assign access = bus.memRead_mem | bus.memWrite_mem;
  assign addr   = bus.ALU_result_mem[ADDR_W-1:0];

  // an access finishes on this edge when its wait states are used up
  always_comb begin
    complete = 1'b0;
    if (state == WAIT) complete = access && (cnt == '0);
    else               complete = access && !HAS_WAIT;
  end

  assign stall       = access & ~complete;
  assign bus.stall_o = stall;

  // wait-state sequencer: IDLE -> WAIT counts down, returns on completion
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (state == IDLE) begin
      if (access && HAS_WAIT) begin
        state <= WAIT;
        cnt   <= CNT_LOAD;
      end
    end else begin
      // upstream dropping the request mid-wait just abandons it
      if (!access || cnt == '0) state <= IDLE;
      else                      cnt   <= cnt - 1'b1;
    end
  end

  // MEM/WB register: bubble while stalled, otherwise capture the instruction
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.ALU_result_wb <= '0;
      bus.Rd_wb         <= '0;
      bus.regWrite_wb   <= 1'b0;
      bus.memToReg_wb   <= 1'b0;
    end else if (stall) begin
      bus.ALU_result_wb <= BUBBLE_REG;
      bus.Rd_wb         <= BUBBLE_RD;
      bus.regWrite_wb   <= BUBBLE_RW;
      bus.memToReg_wb   <= BUBBLE_M2R;
    end else begin
      bus.ALU_result_wb <= bus.ALU_result_mem;
      bus.Rd_wb         <= bus.Rd_mem;
      bus.regWrite_wb   <= bus.regWrite_mem;
      bus.memToReg_wb   <= complete & bus.memRead_mem;
    end
  end

  mem_stage_data_mem #(.ADDR_W(ADDR_W)) u_dmem (
    .clk   (clk),
    .rst   (rst),
    .rd_en (complete & bus.memRead_mem),
    .wr_en (complete & bus.memWrite_mem),
    .addr  (addr),
    .wdata (bus.Rs_data_mem),
    .rdata (bus.mem_data_wb)
  );

  // loads are not forwardable: their data only exists after this stage
  assign bus.fwd_data_o     = bus.ALU_result_mem;
  assign bus.fwd_Rd_o       = bus.Rd_mem;
  assign bus.fwd_regWrite_o = bus.regWrite_mem & ~bus.memRead_mem;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances with 0, 2 and 3 wait states.
module tb_mem_stage;
  import mem_stage_pkg::*;

  logic       clk = 1'b0;
  logic [2:0] rst;
  always #5 clk = ~clk;

  mem_stage_if b0 ();
  mem_stage_if b2 ();
  mem_stage_if b3 ();

  mem_stage #(.ADDR_W(12), .WAIT_STATES(0)) u0 (.clk(clk), .rst(rst[0]), .bus(b0));
  mem_stage #(.ADDR_W(12), .WAIT_STATES(2)) u2 (.clk(clk), .rst(rst[1]), .bus(b2));
  mem_stage #(.ADDR_W(12), .WAIT_STATES(3)) u3 (.clk(clk), .rst(rst[2]), .bus(b3));

  typedef struct {
    logic [15:0] alu, rs;
    logic [2:0]  rd;
    logic        mr, mw, rw;
  } in_t;

  typedef struct {
    logic        stall;
    logic [15:0] alu_wb, md_wb;
    logic [2:0]  rd_wb;
    logic        rw_wb, m2r_wb;
    logic [15:0] fd;
    logic [2:0]  frd;
    logic        fr;
  } out_t;

  typedef struct {
    in_t         i;
    logic [15:0] e_fd;
    logic [2:0]  e_frd;
    logic        e_fr;
    logic [15:0] e_alu, e_md;
    logic [2:0]  e_rd;
    logic        e_rw, e_m2r;
  } vec_t;

  int compared   = 0;
  int mismatched = 0;

  function automatic in_t mk(input logic [15:0] alu, input logic [15:0] rs,
                             input logic [2:0] rd, input logic mr,
                             input logic mw, input logic rw);
    in_t v;
    v.alu = alu; v.rs = rs; v.rd = rd; v.mr = mr; v.mw = mw; v.rw = rw;
    return v;
  endfunction

  task automatic drive(input int d, input in_t v);
    case (d)
      0: begin
        b0.ALU_result_mem = v.alu; b0.Rs_data_mem = v.rs; b0.Rd_mem = v.rd;
        b0.memRead_mem = v.mr; b0.memWrite_mem = v.mw; b0.regWrite_mem = v.rw;
      end
      2: begin
        b2.ALU_result_mem = v.alu; b2.Rs_data_mem = v.rs; b2.Rd_mem = v.rd;
        b2.memRead_mem = v.mr; b2.memWrite_mem = v.mw; b2.regWrite_mem = v.rw;
      end
      default: begin
        b3.ALU_result_mem = v.alu; b3.Rs_data_mem = v.rs; b3.Rd_mem = v.rd;
        b3.memRead_mem = v.mr; b3.memWrite_mem = v.mw; b3.regWrite_mem = v.rw;
      end
    endcase
  endtask

  function automatic out_t sample(input int d);
    out_t o;
    case (d)
      0: begin
        o.stall = b0.stall_o; o.alu_wb = b0.ALU_result_wb; o.md_wb = b0.mem_data_wb;
        o.rd_wb = b0.Rd_wb; o.rw_wb = b0.regWrite_wb; o.m2r_wb = b0.memToReg_wb;
        o.fd = b0.fwd_data_o; o.frd = b0.fwd_Rd_o; o.fr = b0.fwd_regWrite_o;
      end
      2: begin
        o.stall = b2.stall_o; o.alu_wb = b2.ALU_result_wb; o.md_wb = b2.mem_data_wb;
        o.rd_wb = b2.Rd_wb; o.rw_wb = b2.regWrite_wb; o.m2r_wb = b2.memToReg_wb;
        o.fd = b2.fwd_data_o; o.frd = b2.fwd_Rd_o; o.fr = b2.fwd_regWrite_o;
      end
      default: begin
        o.stall = b3.stall_o; o.alu_wb = b3.ALU_result_wb; o.md_wb = b3.mem_data_wb;
        o.rd_wb = b3.Rd_wb; o.rw_wb = b3.regWrite_wb; o.m2r_wb = b3.memToReg_wb;
        o.fd = b3.fwd_data_o; o.frd = b3.fwd_Rd_o; o.fr = b3.fwd_regWrite_o;
      end
    endcase
    return o;
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_wb(input string name, input int d, input logic [15:0] alu,
                        input logic [15:0] md, input logic [2:0] rd,
                        input logic rw, input logic m2r);
    out_t o;
    o = sample(d);
    chk({name, " ALU_result_wb"}, o.alu_wb, alu);
    chk({name, " mem_data_wb"}, o.md_wb, md);
    chk({name, " Rd_wb"}, 16'(o.rd_wb), 16'(rd));
    chk({name, " regWrite_wb"}, 16'(o.rw_wb), 16'(rw));
    chk({name, " memToReg_wb"}, 16'(o.m2r_wb), 16'(m2r));
  endtask

  // Apply one access, count stall cycles (bounded), check bubbles, step
  // through the completion edge and leave the stage idle-driven.
  task automatic run_access(input int d, input in_t v, input int exp_stalls,
                            input string name);
    int   n;
    out_t o;
    n = 0;
    drive(d, v);
    #1;
    o = sample(d);
    while (o.stall && n < 20) begin
      n++;
      tick();
      o = sample(d);
      chk({name, " bubble regWrite_wb"}, 16'(o.rw_wb), 16'h0);
      chk({name, " bubble Rd_wb"}, 16'(o.rd_wb), 16'h0);
    end
    chk({name, " stall cycles"}, 16'(n), 16'(exp_stalls));
    tick();
    drive(d, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0));
  endtask

  vec_t vt[8];

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    out_t o;

    vt[0] = '{mk(16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0), 16'h0010, 3'd0, 1'b0, 16'h0010, 16'h0000, 3'd0, 1'b0, 1'b0};
    vt[1] = '{mk(16'h0010, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1), 16'h0010, 3'd3, 1'b0, 16'h0010, 16'hBEEF, 3'd3, 1'b1, 1'b1};
    vt[2] = '{mk(16'h1234, 16'h0000, 3'd5, 1'b0, 1'b0, 1'b1), 16'h1234, 3'd5, 1'b1, 16'h1234, 16'hBEEF, 3'd5, 1'b1, 1'b0};
    vt[3] = '{mk(16'h1234, 16'h5A5A, 3'd0, 1'b0, 1'b1, 1'b0), 16'h1234, 3'd0, 1'b0, 16'h1234, 16'hBEEF, 3'd0, 1'b0, 1'b0};
    vt[4] = '{mk(16'h1234, 16'h0000, 3'd5, 1'b1, 1'b0, 1'b1), 16'h1234, 3'd5, 1'b0, 16'h1234, 16'h5A5A, 3'd5, 1'b1, 1'b1};
    vt[5] = '{mk(16'hF005, 16'h0A0A, 3'd0, 1'b0, 1'b1, 1'b0), 16'hF005, 3'd0, 1'b0, 16'hF005, 16'h5A5A, 3'd0, 1'b0, 1'b0};
    vt[6] = '{mk(16'h0005, 16'h0000, 3'd2, 1'b1, 1'b0, 1'b1), 16'h0005, 3'd2, 1'b0, 16'h0005, 16'h0A0A, 3'd2, 1'b1, 1'b1};
    vt[7] = '{mk(16'h0007, 16'h0000, 3'd6, 1'b0, 1'b0, 1'b1), 16'h0007, 3'd6, 1'b1, 16'h0007, 16'h0A0A, 3'd6, 1'b1, 1'b0};

    rst = 3'b111;
    for (int d = 0; d < 4; d++) drive(d, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    tick();
    tick();
    rst = 3'b000;

    // reset state
    for (int k = 0; k < 2; k++) begin
      int d;
      d = k * 3;
      o = sample(d);
      chk($sformatf("rst%0d stall_o", d), 16'(o.stall), 16'h0);
      chk_wb($sformatf("rst%0d", d), d, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    end

    // zero-wait-state table: forwarding before the edge, MEM/WB after it
    for (int k = 0; k < 8; k++) begin
      drive(0, vt[k].i);
      #1;
      o = sample(0);
      chk($sformatf("v%0d stall_o", k), 16'(o.stall), 16'h0);
      chk($sformatf("v%0d fwd_data_o", k), o.fd, vt[k].e_fd);
      chk($sformatf("v%0d fwd_Rd_o", k), 16'(o.frd), 16'(vt[k].e_frd));
      chk($sformatf("v%0d fwd_regWrite_o", k), 16'(o.fr), 16'(vt[k].e_fr));
      tick();
      chk_wb($sformatf("v%0d", k), 0, vt[k].e_alu, vt[k].e_md, vt[k].e_rd,
             vt[k].e_rw, vt[k].e_m2r);
    end
    drive(0, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0));

    // three wait states: store, load, then a back-to-back load
    run_access(3, mk(16'h0010, 16'hBEEF, 3'd0, 1'b0, 1'b1, 1'b0), 3, "ws3 store");
    run_access(3, mk(16'h0010, 16'h0000, 3'd3, 1'b1, 1'b0, 1'b1), 3, "ws3 load");
    chk_wb("ws3 load", 3, 16'h0010, 16'hBEEF, 3'd3, 1'b1, 1'b1);
    run_access(3, mk(16'h0010, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1), 3, "ws3 b2b load");
    chk_wb("ws3 b2b load", 3, 16'h0010, 16'hBEEF, 3'd4, 1'b1, 1'b1);

    // reset in the 2nd stall cycle of a store discards it
    run_access(3, mk(16'h0020, 16'h1357, 3'd0, 1'b0, 1'b1, 1'b0), 3, "ws3 prior store");
    drive(3, mk(16'h0020, 16'h5555, 3'd0, 1'b0, 1'b1, 1'b0));
    #1;
    o = sample(3);
    chk("ws3 rst stall first", 16'(o.stall), 16'h1);
    tick();
    o = sample(3);
    chk("ws3 rst stall second", 16'(o.stall), 16'h1);
    rst[2] = 1'b1;
    tick();
    rst[2] = 1'b0;
    drive(3, mk(16'h0, 16'h0, 3'd0, 1'b0, 1'b0, 1'b0));
    #1;
    o = sample(3);
    chk("ws3 after rst stall_o", 16'(o.stall), 16'h0);
    chk_wb("ws3 after rst", 3, 16'h0, 16'h0, 3'd0, 1'b0, 1'b0);
    run_access(3, mk(16'h0020, 16'h0000, 3'd1, 1'b1, 1'b0, 1'b1), 3, "ws3 post-rst load");
    chk_wb("ws3 post-rst load", 3, 16'h0020, 16'h1357, 3'd1, 1'b1, 1'b1);

    // two wait states: read and write together returns the old word
    run_access(2, mk(16'h0030, 16'h1111, 3'd0, 1'b0, 1'b1, 1'b0), 2, "ws2 store");
    run_access(2, mk(16'h0030, 16'h2222, 3'd4, 1'b1, 1'b1, 1'b1), 2, "ws2 rd+wr");
    chk_wb("ws2 rd+wr", 2, 16'h0030, 16'h1111, 3'd4, 1'b1, 1'b1);
    run_access(2, mk(16'h0030, 16'h0000, 3'd4, 1'b1, 1'b0, 1'b1), 2, "ws2 reload");
    chk_wb("ws2 reload", 2, 16'h0030, 16'h2222, 3'd4, 1'b1, 1'b1);

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
Memory-access pipeline stage. It sits directly downstream of the EX/MEM pipeline register and consumes that register's outputs: ALU result, Rs data, destination register and the memRead/memWrite/regWrite controls. It holds the 16-bit data memory, applies a configurable wait-state stall, and drives the MEM/WB pipeline register outputs that feed write-back. It also exposes the current-stage destination and data to the forwarding unit.

Parameters:
ADDR_W, 12, data-memory address width; memory depth is 2**ADDR_W words of 16 bits.
WAIT_STATES, 0, extra stall cycles per memory access (0..15); 0 gives a single-cycle access.

Ports:
clk  input  1  pipeline clock; all state updates on posedge.
rst  input  1  synchronous, active-high reset.
ALU_result_mem  input  16  effective address for loads/stores; result data for ALU instructions.
Rs_data_mem  input  16  store data.
Rd_mem  input  3  destination register.
memRead_mem  input  1  load request.
memWrite_mem  input  1  store request.
regWrite_mem  input  1  instruction writes the register file.
stall_o  output  1  high while an access is in progress; upstream holds all inputs stable while it is high.
ALU_result_wb  output  16  registered ALU result.
mem_data_wb  output  16  registered load data.
Rd_wb  output  3  registered destination.
regWrite_wb  output  1  registered write enable.
memToReg_wb  output  1  registered select; 1 = write back mem_data_wb.
fwd_data_o  output  16  combinational copy of ALU_result_mem, for forwarding.
fwd_Rd_o  output  3  combinational copy of Rd_mem.
fwd_regWrite_o  output  1  regWrite_mem & ~memRead_mem; loads are not forwardable from this stage.

Behaviour:
- Reset, synchronous: all *_wb outputs 0, FSM in IDLE, counter 0, stall_o 0. Memory contents are not cleared.
- Address is ALU_result_mem[ADDR_W-1:0]. Upper bits are ignored, so addresses wrap modulo the depth.
- access = memRead_mem | memWrite_mem.
- FSM has two states, IDLE and WAIT, plus a 4-bit counter cnt.
- IDLE with no access: the MEM/WB register loads the inputs directly. memToReg_wb=0, mem_data_wb holds its previous value, stall_o=0.
- IDLE with access and WAIT_STATES=0: the access completes this edge.
- IDLE with access and WAIT_STATES>0: stall_o=1 combinationally. Next state is WAIT, cnt loads WAIT_STATES-1, and MEM/WB loads a bubble (regWrite_wb=0, memToReg_wb=0, Rd_wb=0).
- WAIT with cnt!=0: stall_o=1, cnt decrements, MEM/WB loads a bubble.
- WAIT with cnt==0: stall_o=0, the access completes this edge, and the next state is IDLE.
- Access completion at one edge:
  - A store writes Rs_data_mem to mem[addr] exactly once.
  - A load registers mem[addr] (the pre-edge contents) into mem_data_wb with memToReg_wb=1.
  - ALU_result_wb, Rd_wb and regWrite_wb load from the inputs.
- Timing: total access time is WAIT_STATES+1 cycles, with stall_o high for WAIT_STATES of them. Write-back outputs are valid one cycle after completion.
- memRead and memWrite both high is illegal from decode. It is handled as a store plus a read-before-write: mem_data_wb gets the old word and memToReg_wb=1.
- Back-to-back accesses: completing in WAIT and seeing a new access in the following IDLE cycle restarts the stall. No idle cycle is inserted by the block.
- Reset asserted mid-access: at that edge FSM returns to IDLE, cnt=0, a pending store is discarded (no memory write), and stall_o is 0 from the next cycle.
- Forward outputs are purely combinational from the inputs and ignore stall_o.

Decomposition:
- Shared pipeline package holds REG_W=16, RD_W=3, the FSM state encoding (IDLE=0, WAIT=1) and the bubble value for MEM/WB fields.
- One sub-module is natural: data_mem (single-port, synchronous write, read-before-write registered read, parameterised by ADDR_W).

Test Plan:
- WAIT_STATES=0: store Rs=16'hBEEF at ALU=16'h0010, then load from 16'h0010 with Rd=3 → next cycle mem_data_wb=16'hBEEF, memToReg_wb=1, Rd_wb=3, stall_o never asserted.
- WAIT_STATES=3: load from 16'h0010 → stall_o high 3 cycles with regWrite_wb=0 during them; completes on the 4th edge with mem_data_wb=16'hBEEF.
- ALU instruction ALU=16'h1234, Rd=5, regWrite=1 → fwd_data_o=16'h1234, fwd_Rd_o=5, fwd_regWrite_o=1 in the same cycle; next cycle ALU_result_wb=16'h1234, memToReg_wb=0. The same instruction with memRead=1 → fwd_regWrite_o=0.
- ADDR_W=12: store 16'h0A0A at ALU=16'hF005, then load ALU=16'h0005 → 16'h0A0A (wrap).
- WAIT_STATES=3: store 16'h5555 to 16'h0020, assert rst in the 2nd stall cycle → stall_o 0 after reset, all *_wb 0; a later load of 16'h0020 returns the prior contents, not 16'h5555.
- WAIT_STATES=2: memRead=memWrite=1 at 16'h0030 holding 16'h1111, with Rs=16'h2222 → mem_data_wb=16'h1111; a subsequent load of 16'h0030 returns 16'h2222.
